execute_stage: RTL

Execute stage of the 5-stage MIPS pipeline. It takes the outputs of the `decode_execute_stage` latch, selects forwarded operands, and computes the ALU result, memory write data and destination register for the EX/MEM latch. It also owns the HI/LO registers and an iterative multiply/divide unit. While that unit is busy, the block stalls the front of the pipeline.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 rtl/execute_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: opcodes, function fields,
// forwarding/regDest selects and the mul/div FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_FIX,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(input logic [5:0] func);
        return (func[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO,
// one bit per cycle on operand magnitudes, signs fixed up at the end.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clock,
    input  logic               reset_i,
    input  logic               en_pipeline_i,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic               signed_i,
    input  logic               mthi_i,
    input  logic               mtlo_i,
    input  logic [NB_DATA-1:0] op_a_i,
    input  logic [NB_DATA-1:0] op_b_i,
    output logic [NB_DATA-1:0] hi_o,
    output logic [NB_DATA-1:0] lo_o,
    output logic               busy_o,
    output logic               stall_o
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    md_state_e state_q, state_d;
    logic [NB_CNT-1:0]    count_q, count_d;
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0]   dsor_q, dsor_d;
    logic [NB_DATA-1:0]   dvd_q, dvd_d;
    logic [NB_DATA-1:0]   hi_q, hi_d;
    logic [NB_DATA-1:0]   lo_q, lo_d;
    logic is_div_q, is_div_d, sgn_q, sgn_d;
    logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic div0_q, div0_d;

    logic [NB_DATA-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [NB_DATA:0]     mul_sum, rem_sh, diff;
    logic [2*NB_DATA-1:0] step, prod_fix;

    always_comb begin
        mag_a = (signed_i && op_a_i[NB_DATA-1]) ? -op_a_i : op_a_i;
        mag_b = (signed_i && op_b_i[NB_DATA-1]) ? -op_b_i : op_b_i;
        mul_sum = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]}
                + {1'b0, (acc_q[0] ? dsor_q : {NB_DATA{1'b0}})};
        rem_sh = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
        diff   = rem_sh - {1'b0, dsor_q};
        if (is_div_q) begin
            step = diff[NB_DATA]
                 ? {rem_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0}
                 : {diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
        end else begin
            step = {mul_sum, acc_q[NB_DATA-1:1]};
        end
        prod_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -acc_q : acc_q;
        quo_fix  = (sgn_q && (neg_a_q ^ neg_b_q))
                 ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
        rem_fix  = (sgn_q && neg_a_q)
                 ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        dsor_d   = dsor_q;
        dvd_d    = dvd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d  = MD_BUSY;
                    count_d  = '0;
                    // mul: low half holds multiplier; div: low half holds dividend
                    acc_d    = {{NB_DATA{1'b0}}, (is_div_i ? mag_a : mag_b)};
                    dsor_d   = is_div_i ? mag_b : mag_a;
                    dvd_d    = op_a_i;
                    is_div_d = is_div_i;
                    sgn_d    = signed_i;
                    neg_a_d  = op_a_i[NB_DATA-1];
                    neg_b_d  = op_b_i[NB_DATA-1];
                    div0_d   = (op_b_i == '0);
                end else if (en_pipeline_i) begin
                    if (mthi_i) hi_d = op_a_i;
                    if (mtlo_i) lo_d = op_a_i;
                end
            end
            MD_BUSY: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == CNT_LAST) state_d = MD_FIX;
            end
            MD_FIX: begin
                state_d = MD_DONE;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
                    lo_d = prod_fix[NB_DATA-1:0];
                end else if (div0_q) begin
                    hi_d = dvd_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            MD_DONE: begin
                if (en_pipeline_i) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(negedge clock) begin
        if (!reset_i) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            dsor_q   <= '0;
            dvd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            dsor_q   <= dsor_d;
            dvd_q    <= dvd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
        end
    end

    assign busy_o  = (state_q == MD_BUSY) || (state_q == MD_FIX);
    assign stall_o = reset_i && (busy_o || ((state_q == MD_IDLE) && start_i));
    assign hi_o    = reset_i ? hi_q : '0;
    assign lo_o    = reset_i ? lo_q : '0;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, destination select and
// the HI/LO mul/div unit that stalls the front of the pipeline.
module execute_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_FUNCTION = 6,
    parameter int NB_OP       = 6,
    parameter int N_REGDEST   = 2
) (
    input  logic                   clock,
    input  logic                   reset_i,
    input  logic                   en_pipeline_i,
    input  logic [NB_DATA-1:0]     pc_i,
    input  logic [NB_DATA-1:0]     data_ra_i,
    input  logic [NB_DATA-1:0]     data_rb_i,
    input  logic [NB_DATA-1:0]     inm_ext_i,
    input  logic                   tipeI_i,
    input  logic [NB_FUNCTION-1:0] function_i,
    input  logic [NB_OP-1:0]       opcode_i,
    input  logic [N_REGDEST-1:0]   regDest_signal_i,
    input  logic [NB_REG-1:0]      register_b_i,
    input  logic [NB_REG-1:0]      register_rw_i,
    input  logic [1:0]             fwd_a_sel_i,
    input  logic [1:0]             fwd_b_sel_i,
    input  logic [NB_DATA-1:0]     ex_mem_data_i,
    input  logic [NB_DATA-1:0]     mem_wb_data_i,
    output logic [NB_DATA-1:0]     alu_result_o,
    output logic [NB_DATA-1:0]     data_write_mem_o,
    output logic [NB_REG-1:0]      register_rw_o,
    output logic                   stall_o,
    output logic [NB_DATA-1:0]     hi_o,
    output logic [NB_DATA-1:0]     lo_o
);

    logic [NB_DATA-1:0] opa, opb, alu_b, zimm, alu_res;
    logic [4:0] shamt;
    logic is_r, md_start, md_busy;

    always_comb begin
        unique case (fwd_a_sel_i)
            FWD_EXMEM: opa = ex_mem_data_i;
            FWD_MEMWB: opa = mem_wb_data_i;
            default:   opa = data_ra_i;
        endcase
        unique case (fwd_b_sel_i)
            FWD_EXMEM: opb = ex_mem_data_i;
            FWD_MEMWB: opb = mem_wb_data_i;
            default:   opb = data_rb_i;
        endcase
    end

    assign alu_b    = tipeI_i ? inm_ext_i : opb;
    assign zimm     = {{(NB_DATA-16){1'b0}}, inm_ext_i[15:0]};
    assign shamt    = inm_ext_i[10:6];
    assign is_r     = (opcode_i == OP_RTYPE);
    assign md_start = is_r && is_muldiv(function_i);

    muldiv_unit #(.NB_DATA(NB_DATA)) u_muldiv (
        .clock         (clock),
        .reset_i       (reset_i),
        .en_pipeline_i (en_pipeline_i),
        .start_i       (md_start),
        .is_div_i      (function_i[1]),
        .signed_i      (!function_i[0]),
        .mthi_i        (is_r && (function_i == F_MTHI)),
        .mtlo_i        (is_r && (function_i == F_MTLO)),
        .op_a_i        (opa),
        .op_b_i        (opb),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .busy_o        (md_busy),
        .stall_o       (stall_o)
    );

    always_comb begin
        alu_res = '0;
        unique case (opcode_i)
            OP_RTYPE: begin
                unique case (function_i)
                    F_ADDU:  alu_res = opa + alu_b;
                    F_SUBU:  alu_res = opa - alu_b;
                    F_AND:   alu_res = opa & alu_b;
                    F_OR:    alu_res = opa | alu_b;
                    F_XOR:   alu_res = opa ^ alu_b;
                    F_NOR:   alu_res = ~(opa | alu_b);
                    F_SLT:   alu_res = NB_DATA'($signed(opa) < $signed(alu_b));
                    F_SLTU:  alu_res = NB_DATA'(opa < alu_b);
                    F_SLL:   alu_res = alu_b << shamt;
                    F_SRL:   alu_res = alu_b >> shamt;
                    F_SRA:   alu_res = $signed(alu_b) >>> shamt;
                    F_SLLV:  alu_res = alu_b << opa[4:0];
                    F_SRLV:  alu_res = alu_b >> opa[4:0];
                    F_SRAV:  alu_res = $signed(alu_b) >>> opa[4:0];
                    F_MFHI:  alu_res = hi_o;
                    F_MFLO:  alu_res = lo_o;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_LWU, OP_SB, OP_SH, OP_SW:
                     alu_res = opa + alu_b;
            OP_SLTI:  alu_res = NB_DATA'($signed(opa) < $signed(alu_b));
            OP_SLTIU: alu_res = NB_DATA'(opa < alu_b);
            OP_ANDI:  alu_res = opa & zimm;
            OP_ORI:   alu_res = opa | zimm;
            OP_XORI:  alu_res = opa ^ zimm;
            OP_LUI:   alu_res = {inm_ext_i[15:0], {(NB_DATA-16){1'b0}}};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        alu_result_o  = alu_res;
        register_rw_o = '0;
        unique case (regDest_signal_i)
            RD_RT:  register_rw_o = register_b_i;
            RD_RD:  register_rw_o = register_rw_i;
            RD_R31: begin
                register_rw_o = NB_REG'(31);
                alu_result_o  = pc_i + NB_DATA'(8);
            end
            default: register_rw_o = '0;
        endcase
    end

    assign data_write_mem_o = opb;

endmodule
